wb_pipe: RTL and testbench
==========================

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter N, default 32, datapath width in bits; legal values 32 and 64.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter CNT_W, default 64, width of the retire counter.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  MEM stage presents an instruction.
REQ-008 in_ready  out  1  stage can accept this cycle.
REQ-009 in_mem2reg  in  2  source select: 00 ALU, 01 load, 10 NPC, 11 IMM.
REQ-010 in_regwrite  in  1  instruction writes the register file.
REQ-011 in_rd  in  RA_W  destination register.
REQ-012 in_alures, in_memread, in_npc, in_imm  in  N each  candidate results.
REQ-013 in_ldfmt  in  3  load format, RISC-V funct3 encoding (LB, LH, LW, LBU, LHU; LWU and LD only when N=64).
REQ-014 in_byteoff  in  log2(N/8)  byte offset of the load address.
REQ-015 stall  in  1  hazard unit freezes the stage.
REQ-016 flush  in  1  kill the instruction held in the stage.
REQ-017 rf_we, rf_waddr, rf_wdata  out  1 / RA_W / N  register-file write port, all registered.
REQ-018 retired  out  1  one-cycle pulse for each retired instruction.
REQ-019 instret  out  CNT_W  retire count (present only with WB_INSTRET_EN).

Function
REQ-020 The stage holds one slot (valid bit plus payload); in_ready = !stall || !slot_valid.
REQ-021 On a rising edge with in_valid && in_ready && !flush, the stage captures the payload and sets slot_valid=1; with !in_valid && in_ready, slot_valid is cleared.
REQ-022 With stall=1 and slot_valid=1, the slot and all outputs hold their values, and rf_we is deasserted for every frozen cycle after the first.
REQ-023 flush=1 has priority over capture and stall: slot_valid clears, rf_we=0 and retired=0 on the next edge.
REQ-024 Latency: rf_we, rf_waddr, rf_wdata and retired reflect an accepted instruction exactly one cycle after acceptance.
REQ-025 rf_wdata = the selected source; for 01 it is the load data shifted right by 8*in_byteoff, then sign- or zero-extended per in_ldfmt.
REQ-026 rf_we = 1 only if the instruction was accepted, in_regwrite=1 and in_rd != 0; writes to x0 are suppressed but still retire.
REQ-027 Undefined in_ldfmt, or a misaligned halfword or word offset: rf_wdata is zero, rf_we=0, and the instruction still retires.
REQ-028 retired pulses once per accepted, unflushed instruction, regardless of in_regwrite.

Reset
REQ-029 While rst=1: slot_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, retired=0, instret=0, and in_ready=1.
REQ-030 Reset mid-operation discards the held instruction with no write and no retire; the first capture is possible on the first edge after rst falls.

Configuration
REQ-031 Macro WB_INSTRET_EN defined: instret port and CNT_W counter exist; the counter increments by 1 on each retired pulse and wraps from all-ones to 0.
REQ-032 WB_INSTRET_EN undefined: the instret port and the counter are absent; all other behaviour is identical.

Structure
REQ-033 Package wb_pkg holds the mem2reg_e enum (ALU, MEM, NPC, IMM), the ldfmt_e enum (funct3 values) and the XLEN default constant.
REQ-034 Load alignment and extension live in sub-module wb_ldext (combinational, parametrised by N); the pipeline slot and the source mux stay in wb_pipe.

Verification
REQ-035 ALU writeback: in_mem2reg=00, alures=0x1234_5678, rd=5, regwrite=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678, retired=1.
REQ-036 Load sign extension: memread=0x80FF_7F01, LB, offset 3 -> rf_wdata=0xFFFF_FF80; LHU, offset 2 -> rf_wdata=0x0000_80FF.
REQ-037 x0 write: rd=0, regwrite=1, NPC=0x104 -> rf_we=0, retired=1.
REQ-038 Stall then flush: accept, stall=1 for 3 cycles, then flush=1 -> slot held during the stall, rf_we=0 from the second stalled cycle, no retire after the flush, in_ready=1 afterwards.
REQ-039 Reset mid-stream: rst asserted with slot_valid=1 -> all outputs 0 on the next edge; a new LW accepted on the first edge after rst falls is written one cycle later.
REQ-040 Counter wrap (WB_INSTRET_EN, CNT_W=4): 17 retirements -> instret=1.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
package wb_pkg;

    // Default datapath width (RV32).
    localparam int XLEN = 32;

    // Writeback source select.
    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_NPC = 2'b10,
        M2R_IMM = 2'b11
    } mem2reg_e;

    // Load format, RISC-V funct3 encoding.
    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_D  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101,
        LD_WU = 3'b110
    } ldfmt_e;

endpackage

// File: rtl/wb_ldext.sv
// wb_ldext: combinational load alignment and sign/zero extension.
// Shifts the loaded word down by the byte offset, then extends the selected
// byte/half/word/double to N bits. Undefined formats (including LWU/LD when
// N=32) and misaligned halfword/word/double offsets raise err with result=0.
module wb_ldext
    import wb_pkg::*;
#(
    parameter  int N    = XLEN,
    localparam int BO_W = $clog2(N / 8)
) (
    input  logic [N-1:0]    data,
    input  logic [2:0]      fmt,
    input  logic [BO_W-1:0] off,
    output logic [N-1:0]    result,
    output logic            err
);

    logic [N-1:0] shifted;

    // Bring the addressed byte down to bit 0.
    assign shifted = data >> {off, 3'b000};

    // Select and extend the loaded field according to the load format.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        err    = 1'b0;
        case (fmt)
            LD_B:  result = N'($signed(shifted[7:0]));
            LD_BU: result = N'(shifted[7:0]);
            LD_H:  if (off[0]) err = 1'b1;
                   else        result = N'($signed(shifted[15:0]));
            LD_HU: if (off[0]) err = 1'b1;
                   else        result = N'(shifted[15:0]);
            LD_W:  if (off[1:0] != 2'b00) err = 1'b1;
                   else                   result = N'($signed(shifted[31:0]));
            LD_WU: if (N == 64 && off[1:0] == 2'b00) result = N'(shifted[31:0]);
                   else                              err = 1'b1;
            LD_D:  if (N == 64 && off == '0) result = shifted;
                   else                      err = 1'b1;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_pipe.sv
// wb_pipe: single-slot writeback pipeline stage.
// Captures one instruction from MEM, selects its result (ALU / load / NPC /
// IMM), and presents a registered register-file write plus a retire pulse one
// cycle after acceptance. Optional macro WB_INSTRET_EN adds the instret
// retire counter and its output port.
module wb_pipe
    import wb_pkg::*;
#(
    parameter  int N     = XLEN,
    parameter  int RA_W  = 5,
    parameter  int CNT_W = 64,
    localparam int BO_W  = $clog2(N / 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mem2reg,
    input  logic             in_regwrite,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [N-1:0]     in_alures,
    input  logic [N-1:0]     in_memread,
    input  logic [N-1:0]     in_npc,
    input  logic [N-1:0]     in_imm,
    input  logic [2:0]       in_ldfmt,
    input  logic [BO_W-1:0]  in_byteoff,
    input  logic             stall,
    input  logic             flush,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [N-1:0]     rf_wdata,
`ifdef WB_INSTRET_EN
    output logic [CNT_W-1:0] instret,
`endif
    output logic             retired
);

    // Elaboration-time guards on the legal parameter space.
    if (!(N == 32 || N == 64)) begin : g_bad_n
        $error("wb_pipe: N must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("wb_pipe: CNT_W must be at least 1");
    end

    logic         slot_valid;
    logic [N-1:0] ld_data;
    logic         ld_err;
    logic [N-1:0] wb_data;
    logic         wb_ok;

    // The slot can take a new instruction unless it is occupied and frozen.
    assign in_ready = rst || !stall || !slot_valid;

    wb_ldext #(.N(N)) u_ldext (
        .data   (in_memread),
        .fmt    (in_ldfmt),
        .off    (in_byteoff),
        .result (ld_data),
        .err    (ld_err)
    );

    // Writeback source mux; a bad load suppresses the write but not the retire.
    always_comb begin
        wb_data = in_alures;
        wb_ok   = 1'b1;
        case (in_mem2reg)
            M2R_ALU: wb_data = in_alures;
            M2R_MEM: begin
                wb_data = ld_data;
                wb_ok   = !ld_err;
            end
            M2R_NPC: wb_data = in_npc;
            M2R_IMM: wb_data = in_imm;
            default: wb_data = in_alures;
        endcase
    end

    // Slot register: reset, then flush, then capture/drain, else frozen.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            slot_valid <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            retired    <= 1'b0;
        end else if (flush) begin
            slot_valid <= 1'b0;
            rf_we      <= 1'b0;
            retired    <= 1'b0;
        end else if (in_ready) begin
            if (in_valid) begin
                slot_valid <= 1'b1;
                rf_we      <= in_regwrite && (in_rd != '0) && wb_ok;
                rf_waddr   <= in_rd;
                rf_wdata   <= wb_data;
                retired    <= 1'b1;
            end else begin
                slot_valid <= 1'b0;
                rf_we      <= 1'b0;
                retired    <= 1'b0;
            end
        end else begin
            // Frozen: payload holds, but the write and retire fire only once.
            rf_we   <= 1'b0;
            retired <= 1'b0;
        end
    end

`ifdef WB_INSTRET_EN
    // Retire counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst)          instret <= '0;
        else if (retired) instret <= instret + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe: directed, table-driven bench for wb_pipe (N=32, RA_W=5, CNT_W=4).
module tb_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mem2reg;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [31:0] in_alures, in_memread, in_npc, in_imm;
    logic [2:0]  in_ldfmt;
    logic [1:0]  in_byteoff;
    logic        stall, flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retired;
`ifdef WB_INSTRET_EN
    logic [3:0]  instret;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pipe #(.N(32), .RA_W(5), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mem2reg  (in_mem2reg),
        .in_regwrite (in_regwrite),
        .in_rd       (in_rd),
        .in_alures   (in_alures),
        .in_memread  (in_memread),
        .in_npc      (in_npc),
        .in_imm      (in_imm),
        .in_ldfmt    (in_ldfmt),
        .in_byteoff  (in_byteoff),
        .stall       (stall),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
`ifdef WB_INSTRET_EN
        .instret     (instret),
`endif
        .retired     (retired)
    );

    typedef struct {
        logic [1:0]  m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] src;
        logic [2:0]  fmt;
        logic [1:0]  off;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] m2r, logic rw, logic [4:0] rd, logic [31:0] src,
                                logic [2:0] fmt, logic [1:0] off, logic we, logic [31:0] data);
        vec_t v;
        v.m2r = m2r; v.rw = rw; v.rd = rd; v.src = src;
        v.fmt = fmt; v.off = off; v.exp_we = we; v.exp_data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put one instruction on the inputs; unselected sources carry distractors.
    task automatic drive(input vec_t v);
        in_valid    = 1'b1;
        in_mem2reg  = v.m2r;
        in_regwrite = v.rw;
        in_rd       = v.rd;
        in_alures   = (v.m2r == 2'b00) ? v.src : 32'hA1A1_A1A1;
        in_memread  = (v.m2r == 2'b01) ? v.src : 32'hB2B2_B2B2;
        in_npc      = (v.m2r == 2'b10) ? v.src : 32'hC3C3_C3C3;
        in_imm      = (v.m2r == 2'b11) ? v.src : 32'hD4D4_D4D4;
        in_ldfmt    = v.fmt;
        in_byteoff  = v.off;
    endtask

    localparam logic [31:0] LDW = 32'h80FF_7F01;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mem2reg = '0; in_regwrite = 1'b0; in_rd = '0;
        in_alures = '0; in_memread = '0; in_npc = '0; in_imm = '0;
        in_ldfmt = '0; in_byteoff = '0; stall = 1'b0; flush = 1'b0;

        vecs[0]  = mk(2'b00, 1, 5'd5,  32'h1234_5678, 3'd0, 2'd0, 1, 32'h1234_5678);
        vecs[1]  = mk(2'b01, 1, 5'd6,  LDW,           3'd0, 2'd3, 1, 32'hFFFF_FF80);
        vecs[2]  = mk(2'b01, 1, 5'd7,  LDW,           3'd5, 2'd2, 1, 32'h0000_80FF);
        vecs[3]  = mk(2'b10, 1, 5'd0,  32'h0000_0104, 3'd0, 2'd0, 0, 32'h0000_0104);
        vecs[4]  = mk(2'b11, 1, 5'd31, 32'hDEAD_0000, 3'd7, 2'd1, 1, 32'hDEAD_0000);
        vecs[5]  = mk(2'b00, 0, 5'd3,  32'hCAFE_BABE, 3'd0, 2'd0, 0, 32'hCAFE_BABE);
        vecs[6]  = mk(2'b01, 1, 5'd8,  LDW,           3'd1, 2'd1, 0, 32'h0000_0000);
        vecs[7]  = mk(2'b01, 1, 5'd9,  LDW,           3'd3, 2'd0, 0, 32'h0000_0000);
        vecs[8]  = mk(2'b01, 1, 5'd10, LDW,           3'd2, 2'd0, 1, 32'h80FF_7F01);
        vecs[9]  = mk(2'b01, 1, 5'd11, LDW,           3'd1, 2'd2, 1, 32'hFFFF_80FF);
        vecs[10] = mk(2'b01, 1, 5'd12, LDW,           3'd4, 2'd1, 1, 32'h0000_007F);
        vecs[11] = mk(2'b01, 1, 5'd13, LDW,           3'd0, 2'd2, 1, 32'hFFFF_FFFF);
        vecs[12] = mk(2'b01, 1, 5'd14, LDW,           3'd2, 2'd2, 0, 32'h0000_0000);
        vecs[13] = mk(2'b01, 1, 5'd15, LDW,           3'd7, 2'd0, 0, 32'h0000_0000);
        vecs[14] = mk(2'b01, 1, 5'd16, LDW,           3'd6, 2'd0, 0, 32'h0000_0000);
        vecs[15] = mk(2'b01, 1, 5'd17, LDW,           3'd5, 2'd0, 1, 32'h0000_7F01);

        // Reset state.
        step(); step();
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Back-to-back table vectors, each visible one cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
            check($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
            check($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_retired", i), 64'(retired), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("idle_retired", 64'(retired), 64'd0);
        check("idle_we", 64'(rf_we), 64'd0);

        // Stall with a waiting instruction, then release it.
        drive(mk(2'b00, 1, 5'd20, 32'h0000_AAAA, 3'd0, 2'd0, 1, 32'h0));
        step();
        drive(mk(2'b11, 1, 5'd21, 32'h0000_BBBB, 3'd0, 2'd0, 1, 32'h0));
        stall = 1'b1;
        #1;
        check("sa_ready_frozen", 64'(in_ready), 64'd0);
        check("sa_first_we", 64'(rf_we), 64'd1);
        step();
        check("sa_hold_we", 64'(rf_we), 64'd0);
        check("sa_hold_retired", 64'(retired), 64'd0);
        check("sa_hold_waddr", 64'(rf_waddr), 64'd20);
        check("sa_hold_wdata", 64'(rf_wdata), 64'h0000_AAAA);
        step();
        check("sa_hold2_waddr", 64'(rf_waddr), 64'd20);
        stall = 1'b0;
        #1;
        check("sa_ready_release", 64'(in_ready), 64'd1);
        step();
        check("sa_b_we", 64'(rf_we), 64'd1);
        check("sa_b_waddr", 64'(rf_waddr), 64'd21);
        check("sa_b_wdata", 64'(rf_wdata), 64'h0000_BBBB);
        check("sa_b_retired", 64'(retired), 64'd1);
        in_valid = 1'b0;
        step();

        // Accept, stall three cycles, then flush with a new instruction offered.
        drive(mk(2'b00, 1, 5'd22, 32'h0000_CCCC, 3'd0, 2'd0, 1, 32'h0));
        step();
        in_valid = 1'b0;
        stall = 1'b1;
        check("sf_accept_we", 64'(rf_we), 64'd1);
        step();
        check("sf_stall1_we", 64'(rf_we), 64'd0);
        check("sf_stall1_wdata", 64'(rf_wdata), 64'h0000_CCCC);
        step();
        check("sf_stall2_retired", 64'(retired), 64'd0);
        check("sf_stall2_ready", 64'(in_ready), 64'd0);
        drive(mk(2'b00, 1, 5'd23, 32'h0000_DDDD, 3'd0, 2'd0, 1, 32'h0));
        flush = 1'b1;
        step();
        check("sf_flush_we", 64'(rf_we), 64'd0);
        check("sf_flush_retired", 64'(retired), 64'd0);
        check("sf_ready_after", 64'(in_ready), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        check("sf_post_retired", 64'(retired), 64'd0);
        stall = 1'b0;

        // Reset mid-stream, then LW on the first edge after reset falls.
        drive(mk(2'b00, 1, 5'd24, 32'h0000_EEEE, 3'd0, 2'd0, 1, 32'h0));
        step();
        rst = 1'b1;
        step();
        check("rm_we", 64'(rf_we), 64'd0);
        check("rm_waddr", 64'(rf_waddr), 64'd0);
        check("rm_wdata", 64'(rf_wdata), 64'd0);
        check("rm_retired", 64'(retired), 64'd0);
        check("rm_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        drive(mk(2'b01, 1, 5'd25, 32'h1122_3344, 3'd2, 2'd0, 1, 32'h0));
        step();
        check("rm_lw_we", 64'(rf_we), 64'd1);
        check("rm_lw_waddr", 64'(rf_waddr), 64'd25);
        check("rm_lw_wdata", 64'(rf_wdata), 64'h1122_3344);
        in_valid = 1'b0;
        step();

`ifdef WB_INSTRET_EN
        // Counter wrap with a 4-bit counter: 17 retirements leave 1.
        rst = 1'b1;
        step();
        check("cnt_reset", 64'(instret), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(mk(2'b00, 1'(i % 2), 5'd0, 32'(i), 3'd0, 2'd0, 0, 32'h0));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("cnt_wrap", 64'(instret), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
